// File: rtl/alu_driver.sv
// Sequential front-end for the 4-bit combinational ALU: accepts one request,
// drives registered command/operands, captures the result and returns it.
module alu_driver #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_cmd,
    input  logic [3:0]       req_a,
    input  logic [3:0]       req_b,
    output logic [2:0]       alu_command,
    output logic [3:0]       inA,
    output logic [3:0]       inB,
    input  logic [3:0]       alu_out,
    input  logic             alu_iszero,
    input  logic             alu_is_overflow,
    input  logic             alu_cout,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [3:0]       resp_data,
    output logic [2:0]       resp_flags,
    output logic [2:0]       resp_cmd,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EVAL = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]       r_state;
    logic [2:0]       r_cmd;
    logic [3:0]       r_a;
    logic [3:0]       r_b;
    logic [3:0]       r_resp_data;
    logic [2:0]       r_resp_flags;
    logic [2:0]       r_resp_cmd;
    logic [CNT_W-1:0] r_op_count;

    logic w_accept;
    logic w_capture;
    logic w_done;

    assign w_accept  = req_valid && (r_state == IDLE);
    assign w_capture = (r_state == EVAL);
    assign w_done    = resp_ready && (r_state == RESP);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE:    r_state <= w_accept ? EVAL : IDLE;
                EVAL:    r_state <= RESP;
                RESP:    r_state <= w_done ? IDLE : RESP;
                default: r_state <= IDLE;
            endcase
        end
    end

    // Drive registers hold their last values while idle so the ALU inputs stay quiet.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cmd <= 3'd0;
            r_a   <= 4'd0;
            r_b   <= 4'd0;
        end else if (w_accept) begin
            r_cmd <= req_cmd;
            r_a   <= req_a;
            r_b   <= req_b;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_resp_data  <= 4'd0;
            r_resp_flags <= 3'd0;
            r_resp_cmd   <= 3'd0;
        end else if (w_capture) begin
            r_resp_data  <= alu_out;
            r_resp_flags <= {alu_cout, alu_is_overflow, alu_iszero};
            r_resp_cmd   <= r_cmd;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_op_count <= '0;
        end else if (w_done) begin
            r_op_count <= r_op_count + 1'b1;
        end
    end

    assign req_ready   = (r_state == IDLE);
    assign resp_valid  = (r_state == RESP);
    assign busy        = (r_state != IDLE);
    assign alu_command = r_cmd;
    assign inA         = r_a;
    assign inB         = r_b;
    assign resp_data   = r_resp_data;
    assign resp_flags  = r_resp_flags;
    assign resp_cmd    = r_resp_cmd;
    assign op_count    = r_op_count;

endmodule
